shift_chain_sched: RTL
======================

// Module: shift_chain_sched
//
// PURPOSE
//   Round-robin scheduler sharing one serial 4-stage shift chain among NREQ requesters.
//   Grants one requester, streams its WIDTH-bit word LSB-first into the chain's
//   serial input, flushes the chain and deserialises the chain's serial output back
//   into a word. Sits between requester blocks and the shift-register datapath.
//
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   WIDTH  8   bits per transfer word
//   DEPTH  4   register stages in the attached chain, serial-in to serial-out
//
// PORTS
//   clk        in   1           rising-edge clock
//   reset      in   1           asynchronous, active-low reset
//   req        in   NREQ        per-requester request level
//   req_data   in   NREQ*WIDTH  word of requester i at [i*WIDTH +: WIDTH]
//   gnt        out  NREQ        one-hot grant, 1-cycle pulse
//   sh_in      out  1           chain serial input (drives chain A)
//   sh_out     in   1           chain serial output (from chain E)
//   busy       out  1           transfer in progress
//   done       out  1           1-cycle pulse, transfer complete
//   rx_data    out  WIDTH       deserialised word, valid while done=1, held after
//   owner      out  $clog2(NREQ) index of requester served by current/last transfer
//
// BEHAVIOUR
//   - Reset (async, reset=0): state IDLE, cnt=0, rr pointer=0; gnt=0, sh_in=0,
//     busy=0, done=0, rx_data=0, owner=0. Reset mid-transfer aborts it: no done pulse.
//   - FSM: IDLE -> SHIFT when any req=1; SHIFT -> DONE when cnt==WIDTH+DEPTH-1;
//     DONE -> IDLE unconditionally (one cycle).
//   - Arbitration in IDLE: first req=1 at/after rr pointer (wrapping NREQ-1 -> 0).
//     On the IDLE->SHIFT edge: latch req_data word and owner, pointer := owner+1 mod NREQ.
//   - gnt[owner]=1 only in the first SHIFT cycle (cnt=0); requester may drop req or
//     change req_data after it. req changes during SHIFT/DONE are ignored.
//   - SHIFT: cnt counts 0..WIDTH+DEPTH-1; sh_in = word[cnt] for cnt<WIDTH, else 0.
//     sh_in is registered so it is glitch-free.
//   - Capture: for cnt in DEPTH..DEPTH+WIDTH-1, rx shift reg shifts right with sh_out
//     into MSB; after WIDTH captures rx_data holds bits LSB-first in correct order.
//   - busy=1 in SHIFT and DONE. done=1 in DONE only. Next grant earliest in cycle
//     after DONE+1 (IDLE must be visited once): back-to-back period WIDTH+DEPTH+2.
//   - Latency: req seen in cycle t (IDLE) -> gnt in t+1 -> done in t+WIDTH+DEPTH+1.
//   - No requests: stays IDLE, sh_in=0, pointer unchanged.
//
// CONFIGURATION
//   LOOPBACK_CHECK_EN defined: extra output err (1 bit, reset 0); in DONE,
//     err = (rx_data != latched word); err valid with done, held until next done.
//   Not defined: no err port, no comparator; all other behaviour identical.
//
// STRUCTURE
//   Package shift_sched_pkg: state_t enum {IDLE, SHIFT, DONE}; CNT_W derivation
//     function; default NREQ/WIDTH/DEPTH constants.
//   Sub-module rr_arbiter (NREQ): req + pointer -> one-hot grant + encoded index.
//   Top holds FSM, counter, word/rx shift registers, optional checker.
//
// TESTING (NREQ=4, WIDTH=8, DEPTH=4, real 4-stage chain in loop)
//   1 req[0]=1, word 8'hA5 -> gnt[0] 1 cycle later; sh_in 1,0,1,0,0,1,0,1,0,0,0,0;
//     done 12 cycles after gnt; rx_data=8'hA5, owner=0.
//   2 req=4'b1111 held, words 11,22,33,44 -> owners 0,1,2,3,0 in order,
//     done pulses 14 cycles apart, rx_data matches each word.
//   3 req[2] held continuously, req[1] raised mid-transfer -> next owner 1, then 2.
//   4 reset=0 at cnt=5 -> all outputs 0 same cycle, no done; after release req[3]
//     served first only if pointer=0 search order reaches it (pointer reset to 0).
//   5 req=0 for 50 cycles -> busy=0, sh_in=0, gnt=0 throughout.
//   6 LOOPBACK_CHECK_EN, chain stuck-at-0 on sh_out, word 8'hFF -> rx_data=8'h00,
//     err=1 with done; healthy chain, 8'h3C -> err=0.

Source files
------------

// File: rtl/shift_sched_pkg.sv
// Shared types and defaults for the shift-chain scheduler.
package shift_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    // Counter spans 0 .. width+depth-1 (serialise plus chain flush).
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned depth);
        return $clog2(width + depth);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    valid_o
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = 32'(ptr_i) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/shift_chain_sched.sv
// Round-robin scheduler sharing one serial shift chain among NREQ requesters.
// Optional LOOPBACK_CHECK_EN adds the err output comparing rx_data with the sent word.
module shift_chain_sched
    import shift_sched_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    sh_in,
    input  logic                    sh_out,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        rx_data,
    output logic [$clog2(NREQ)-1:0] owner
`ifdef LOOPBACK_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = cnt_width(WIDTH, DEPTH);
    localparam int unsigned LAST  = WIDTH + DEPTH - 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   tx_q, tx_d;
    logic               sh_in_q, sh_in_d;
    logic [WIDTH-2:0]   rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic [WIDTH-1:0]   rx_next;
    logic [WIDTH-1:0]   sel_word;

    logic [NREQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_word = sel_word | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rx_next = {sh_out, rx_sh_q};

    // sh_in is registered one cycle ahead: tx_q always holds the bits still to send.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tx_d      = tx_q;
        sh_in_d   = 1'b0;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    owner_d = arb_idx;
                    ptr_d   = (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                    tx_d    = sel_word >> 1;
                    sh_in_d = sel_word[0];
                end
            end
            SHIFT: begin
                if (cnt_q >= CNT_W'(DEPTH)) begin
                    rx_sh_d = rx_next[WIDTH-1:1];
                end
                if (cnt_q == CNT_W'(LAST)) begin
                    state_d   = DONE;
                    cnt_d     = '0;
                    rx_data_d = rx_next;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    sh_in_d = tx_q[0];
                    tx_d    = tx_q >> 1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            tx_q      <= '0;
            sh_in_q   <= 1'b0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            tx_q      <= tx_d;
            sh_in_q   <= sh_in_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == SHIFT && cnt_q == '0) begin
            gnt[owner_q] = 1'b1;
        end
    end

    assign sh_in   = sh_in_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rx_data = rx_data_q;
    assign owner   = owner_q;

`ifdef LOOPBACK_CHECK_EN
    logic [WIDTH-1:0] word_q;
    logic             err_q;

    // err is decided on the same edge that loads rx_data, so both are valid with done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && arb_valid) begin
                word_q <= sel_word;
            end
            if (state_q == SHIFT && cnt_q == CNT_W'(LAST)) begin
                err_q <= (rx_next != word_q);
            end
        end
    end

    assign err = err_q;
`endif

endmodule
